// File: rtl/ahb_lite_i2c_bridge_pkg.sv
// Shared constants and types for the AHB-Lite to I2C register-port bridge:
// I2C core register offsets, AHB HTRANS codes and the bridge FSM state type.
package ahb_lite_i2c_bridge_pkg;

  // I2C master core register offsets (word index on the register port)
  localparam logic [2:0] I2C_REG_PRERLO  = 3'd0;
  localparam logic [2:0] I2C_REG_PRERHI  = 3'd1;
  localparam logic [2:0] I2C_REG_CTR     = 3'd2;
  localparam logic [2:0] I2C_REG_TXR_RXR = 3'd3;
  localparam logic [2:0] I2C_REG_CR_SR   = 3'd4;

  localparam int unsigned I2C_NUM_REGS = 5;

  // AHB HTRANS encodings
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // Largest transfer size the bridge accepts (word)
  localparam logic [2:0] HSIZE_MAX = 3'd2;

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    RESP,
    ERR1,
    ERR2
  } bridge_state_e;

  // True when the word index addresses an implemented register
  function automatic logic reg_index_ok(input logic [2:0] idx);
    return 32'(idx) < I2C_NUM_REGS;
  endfunction

endpackage

// File: rtl/ahb_lite_i2c_bridge_addr_decode.sv
// Combinational address/size decode for the AHB-Lite to I2C bridge.
// Word index is addr[4:2]; everything above bit 4 must be zero and the
// transfer size must not exceed a word.
module ahb_lite_i2c_bridge_addr_decode
  import ahb_lite_i2c_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  output logic [2:0]        idx,
  output logic              legal
);

  logic upper_zero;
  logic unused_byte_lane;

  assign idx        = addr[4:2];
  assign upper_zero = (addr[ADDR_W-1:5] == '0);
  assign legal      = reg_index_ok(idx) && upper_zero && (size <= HSIZE_MAX);

  // Byte-lane bits carry no meaning for 8-bit registers
  assign unused_byte_lane = ^addr[1:0];

endmodule

// File: rtl/ahb_lite_i2c_bridge.sv
// AHB-Lite slave that turns each accepted AHB transfer into one 8-bit access
// on the I2C master core register port, stretching the data phase until the
// core acks and answering illegal accesses with a two-cycle ERROR.
// Optional ack-wait timeout: define I2C_BRIDGE_TIMEOUT_EN.
module ahb_lite_i2c_bridge
  import ahb_lite_i2c_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [31:0]       HRDATA,
  output logic [2:0]        reg_adr_o,
  output logic [7:0]        reg_dat_o,
  input  logic [7:0]        reg_dat_i,
  output logic              reg_we_o,
  output logic              reg_stb_o,
  input  logic              reg_ack_i
);

  bridge_state_e state_q, state_d;

  logic [2:0] adr_q;
  logic       we_q;
  logic [7:0] dat_q;
  logic       first_q;
  logic [7:0] rdata_q;

  logic       dec_legal;
  logic [2:0] dec_idx;
  logic       accept;
  logic       addr_slot;
  logic       take;
  logic       ack_hit;
  logic       timeout_hit;
  logic       unused_hwdata;

  ahb_lite_i2c_bridge_addr_decode #(
    .ADDR_W (ADDR_W)
  ) u_addr_decode (
    .addr  (HADDR),
    .size  (HSIZE),
    .idx   (dec_idx),
    .legal (dec_legal)
  );

  assign accept = HSEL && HREADY && ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
  // States in which a new address phase may be taken (data phase done or none)
  assign addr_slot = (state_q == IDLE) || (state_q == RESP) || (state_q == ERR2);
  assign take      = accept && addr_slot;
  assign ack_hit   = (state_q == ACCESS) && reg_ack_i;

`ifdef I2C_BRIDGE_TIMEOUT_EN
  logic [7:0] wait_cnt_q;

  // Fires on the ACCESS cycle that would bring the unacked count to the limit
  assign timeout_hit = (state_q == ACCESS) && !reg_ack_i &&
                       (wait_cnt_q == 8'(TIMEOUT_CYCLES - 1));

  // Unacked ACCESS cycle counter; held at zero outside ACCESS so entry clears it
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wait_cnt_q <= '0;
    end else if (state_q != ACCESS) begin
      wait_cnt_q <= '0;
    end else if (!reg_ack_i) begin
      wait_cnt_q <= wait_cnt_q + 8'd1;
    end
  end
`else
  logic unused_timeout;

  assign timeout_hit    = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // Next-state logic; an ack beats a timeout in the same cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RESP, ERR2: begin
        if (take) begin
          state_d = dec_legal ? ACCESS : ERR1;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (ack_hit) begin
          state_d = RESP;
        end else if (timeout_hit) begin
          state_d = ERR1;
        end
      end
      ERR1:    state_d = ERR2;
      default: state_d = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture register index and direction at an accepted legal address phase
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      adr_q <= '0;
      we_q  <= 1'b0;
    end else if (take && dec_legal) begin
      adr_q <= dec_idx;
      we_q  <= HWRITE;
    end
  end

  // Write byte: HWDATA is only valid in the first data-phase cycle, so hold it after
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      first_q <= 1'b0;
      dat_q   <= '0;
    end else begin
      first_q <= take && dec_legal;
      if ((state_q == ACCESS) && first_q) begin
        dat_q <= HWDATA[7:0];
      end
    end
  end

  // Read data capture on ack; writes leave the last read byte in place
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      rdata_q <= '0;
    end else if (ack_hit && !we_q) begin
      rdata_q <= reg_dat_i;
    end
  end

  // Pass HWDATA straight through on the first ACCESS cycle so an immediate ack sees it
  assign reg_dat_o = ((state_q == ACCESS) && first_q) ? HWDATA[7:0] : dat_q;
  assign reg_stb_o = (state_q == ACCESS);
  assign reg_we_o  = reg_stb_o && we_q;
  assign reg_adr_o = adr_q;

  assign HREADYOUT = !((state_q == ACCESS) || (state_q == ERR1));
  assign HRESP     = (state_q == ERR1) || (state_q == ERR2);
  assign HRDATA    = {24'h0, rdata_q};

  assign unused_hwdata = ^HWDATA[31:8];

endmodule

// File: tb/tb_ahb_lite_i2c_bridge.sv
// Self-checking bench for ahb_lite_i2c_bridge: a small I2C core model acks
// after a programmable number of strobe cycles; expected data-phase results
// are queued when a transfer is driven and compared when it completes.
module tb_ahb_lite_i2c_bridge;
  import ahb_lite_i2c_bridge_pkg::*;

  localparam int unsigned AW = 8;
`ifdef I2C_BRIDGE_TIMEOUT_EN
  localparam int unsigned TO = 4;
`else
  localparam int unsigned TO = 255;
`endif

  logic          HCLK;
  logic          HRESET;
  logic          HSEL;
  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [31:0]   HWDATA;
  logic          HREADY;
  logic          HREADYOUT;
  logic          HRESP;
  logic [31:0]   HRDATA;
  logic [2:0]    reg_adr_o;
  logic [7:0]    reg_dat_o;
  logic [7:0]    reg_dat_i;
  logic          reg_we_o;
  logic          reg_stb_o;
  logic          reg_ack_i;

  // Observed or expected outcome of one data phase
  typedef struct {
    logic        resp_wait;
    logic        resp;
    logic [31:0] rdata;
    int          low;
    int          stb_cyc;
    logic        stb_first;
    logic [2:0]  adr;
    logic        we;
    logic [7:0]  dat;
  } obs_t;

  obs_t exp_q[$];

  int   n_vec = 0;
  int   n_err = 0;
  int   ack_delay = 0;
  bit   ack_mute = 0;
  bit   ack_force = 0;
  logic [7:0]  rd_byte = 8'h00;
  logic [31:0] rdata_model = 32'h0;

  ahb_lite_i2c_bridge #(
    .ADDR_W         (AW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .HRDATA    (HRDATA),
    .reg_adr_o (reg_adr_o),
    .reg_dat_o (reg_dat_o),
    .reg_dat_i (reg_dat_i),
    .reg_we_o  (reg_we_o),
    .reg_stb_o (reg_stb_o),
    .reg_ack_i (reg_ack_i)
  );

  // Single slave on the bus
  assign HREADY = HREADYOUT;

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  // I2C core model: ack on the (ack_delay+1)-th cycle that strobe is seen high
  initial begin
    int stb_cycles;
    stb_cycles = 0;
    reg_ack_i  = 1'b0;
    reg_dat_i  = 8'h00;
    forever begin
      @(posedge HCLK);
      #2;
      reg_dat_i = rd_byte;
      if (reg_stb_o) begin
        reg_ack_i  = ack_force || (!ack_mute && (stb_cycles == ack_delay));
        stb_cycles = stb_cycles + 1;
      end else begin
        reg_ack_i  = ack_force;
        stb_cycles = 0;
      end
    end
  end

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive_addr(input logic [AW-1:0] a, input logic w, input logic [2:0] s);
    HSEL   = 1'b1;
    HTRANS = HTRANS_NONSEQ;
    HADDR  = a;
    HWRITE = w;
    HSIZE  = s;
  endtask

  task automatic drive_idle();
    HSEL   = 1'b0;
    HTRANS = HTRANS_IDLE;
  endtask

  function automatic obs_t mk_exp(input logic rw, input logic r, input logic [31:0] rd,
                                  input int low, input int stb, input logic [2:0] adr,
                                  input logic we, input logic [7:0] dat);
    obs_t e;
    e = '{resp_wait: rw, resp: r, rdata: rd, low: low, stb_cyc: stb,
          stb_first: (stb > 0), adr: adr, we: we, dat: dat};
    return e;
  endfunction

  // Follow one data phase from just after its address edge to its final cycle
  task automatic collect(output obs_t o);
    o = '{resp_wait: 1'b0, resp: 1'b0, rdata: 32'h0, low: -1, stb_cyc: 0,
          stb_first: 1'b0, adr: 3'h0, we: 1'b0, dat: 8'h0};
    for (int i = 0; i < 300; i++) begin
      @(negedge HCLK);
      if (i == 0) begin
        o.resp_wait = HRESP;
        o.stb_first = reg_stb_o;
      end
      if (reg_stb_o) o.stb_cyc++;
      if (reg_stb_o && reg_ack_i) begin
        o.adr = reg_adr_o;
        o.we  = reg_we_o;
        o.dat = reg_dat_o;
      end
      if (HREADYOUT) begin
        o.resp  = HRESP;
        o.rdata = HRDATA;
        o.low   = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    repeat (2) @(posedge HCLK);
    #1;
    rdata_model = 32'h0;
    n_vec++; if (HREADYOUT !== 1'b1) begin n_err++; $display("FAIL rst_hreadyout: got %b want 1", HREADYOUT); end
    n_vec++; if (HRESP !== 1'b0) begin n_err++; $display("FAIL rst_hresp: got %b want 0", HRESP); end
    n_vec++; if (HRDATA !== rdata_model) begin n_err++; $display("FAIL rst_hrdata: got %h want %h", HRDATA, rdata_model); end
    n_vec++; if (reg_stb_o !== 1'b0) begin n_err++; $display("FAIL rst_stb: got %b want 0", reg_stb_o); end
    n_vec++; if (reg_we_o !== 1'b0) begin n_err++; $display("FAIL rst_we: got %b want 0", reg_we_o); end
    n_vec++; if (reg_adr_o !== 3'd0) begin n_err++; $display("FAIL rst_adr: got %h want 0", reg_adr_o); end
    n_vec++; if (reg_dat_o !== 8'h00) begin n_err++; $display("FAIL rst_dat: got %h want 00", reg_dat_o); end
    HRESET = 1'b0;
    step();
  endtask

  task automatic test_idle_bus();
    logic       sel_tab [3] = '{1'b1, 1'b1, 1'b0};
    logic [1:0] tr_tab  [3] = '{HTRANS_IDLE, HTRANS_BUSY, HTRANS_NONSEQ};
    for (int k = 0; k < 3; k++) begin
      HSEL = sel_tab[k]; HTRANS = tr_tab[k]; HADDR = 8'h08; HWRITE = 1'b1; HSIZE = 3'd0;
      step();
      @(negedge HCLK);
      n_vec++; if (HREADYOUT !== 1'b1) begin n_err++; $display("FAIL idle%0d_ready: got %b want 1", k, HREADYOUT); end
      n_vec++; if (HRESP !== 1'b0) begin n_err++; $display("FAIL idle%0d_resp: got %b want 0", k, HRESP); end
      n_vec++; if (reg_stb_o !== 1'b0) begin n_err++; $display("FAIL idle%0d_stb: got %b want 0", k, reg_stb_o); end
      step();
    end
    drive_idle();
  endtask

  task automatic test_write_prerlo();
    obs_t o, e;
    ack_delay = 2;
    drive_addr(8'h00, 1'b1, 3'd2);
    exp_q.push_back(mk_exp(1'b0, 1'b0, rdata_model, 3, 3, I2C_REG_PRERLO, 1'b1, 8'hC7));
    step();
    drive_idle();
    HWDATA = 32'h0000_00C7;
    collect(o);
    e = exp_q.pop_front();
    n_vec++; if (o.low !== e.low) begin n_err++; $display("FAIL wr_low: got %0d want %0d", o.low, e.low); end
    n_vec++; if (o.stb_cyc !== e.stb_cyc) begin n_err++; $display("FAIL wr_stb: got %0d want %0d", o.stb_cyc, e.stb_cyc); end
    n_vec++; if (o.adr !== e.adr) begin n_err++; $display("FAIL wr_adr: got %h want %h", o.adr, e.adr); end
    n_vec++; if (o.we !== e.we) begin n_err++; $display("FAIL wr_we: got %b want %b", o.we, e.we); end
    n_vec++; if (o.dat !== e.dat) begin n_err++; $display("FAIL wr_dat: got %h want %h", o.dat, e.dat); end
    n_vec++; if (o.resp !== e.resp) begin n_err++; $display("FAIL wr_resp: got %b want %b", o.resp, e.resp); end
    n_vec++; if (o.rdata !== e.rdata) begin n_err++; $display("FAIL wr_hrdata: got %h want %h", o.rdata, e.rdata); end
    step();
  endtask

  // ack_dly is the number of strobe cycles the core waits before acking
  task automatic test_read(input string nm, input logic [AW-1:0] a, input logic [7:0] b,
                           input int ack_dly);
    obs_t o, e;
    ack_delay = ack_dly;
    rd_byte   = b;
    rdata_model = {24'h0, b};
    drive_addr(a, 1'b0, 3'd2);
    exp_q.push_back(mk_exp(1'b0, 1'b0, rdata_model, ack_dly + 1, ack_dly + 1, a[4:2], 1'b0,
                           8'h00));
    step();
    drive_idle();
    HWDATA = 32'h0;
    collect(o);
    e = exp_q.pop_front();
    n_vec++; if (o.low !== e.low) begin n_err++; $display("FAIL %s_low: got %0d want %0d", nm, o.low, e.low); end
    n_vec++; if (o.stb_cyc !== e.stb_cyc) begin n_err++; $display("FAIL %s_stb: got %0d want %0d", nm, o.stb_cyc, e.stb_cyc); end
    n_vec++; if (o.adr !== e.adr) begin n_err++; $display("FAIL %s_adr: got %h want %h", nm, o.adr, e.adr); end
    n_vec++; if (o.we !== e.we) begin n_err++; $display("FAIL %s_we: got %b want %b", nm, o.we, e.we); end
    n_vec++; if (o.rdata !== e.rdata) begin n_err++; $display("FAIL %s_hrdata: got %h want %h", nm, o.rdata, e.rdata); end
    n_vec++; if (o.resp !== e.resp) begin n_err++; $display("FAIL %s_resp: got %b want %b", nm, o.resp, e.resp); end
    step();
  endtask

  task automatic test_illegal();
    obs_t o, e;
    logic [7:0] a_tab [3] = '{8'h14, 8'h20, 8'h04};
    logic [2:0] s_tab [3] = '{3'd0, 3'd0, 3'd3};
    for (int k = 0; k < 3; k++) begin
      drive_addr(a_tab[k], 1'b1, s_tab[k]);
      exp_q.push_back(mk_exp(1'b1, 1'b1, rdata_model, 1, 0, 3'd0, 1'b0, 8'h00));
      step();
      drive_idle();
      collect(o);
      e = exp_q.pop_front();
      n_vec++; if (o.stb_cyc !== e.stb_cyc) begin n_err++; $display("FAIL ill%0d_stb: got %0d want %0d", k, o.stb_cyc, e.stb_cyc); end
      n_vec++; if (o.resp_wait !== e.resp_wait) begin n_err++; $display("FAIL ill%0d_err1: got %b want %b", k, o.resp_wait, e.resp_wait); end
      n_vec++; if (o.low !== e.low) begin n_err++; $display("FAIL ill%0d_low: got %0d want %0d", k, o.low, e.low); end
      n_vec++; if (o.resp !== e.resp) begin n_err++; $display("FAIL ill%0d_err2: got %b want %b", k, o.resp, e.resp); end
      step();
    end
  endtask

  task automatic test_back_to_back();
    obs_t o1, o2, e1, e2;
    ack_delay = 1;
    rd_byte   = 8'h5A;
    drive_addr(8'h0C, 1'b0, 3'd0);
    exp_q.push_back(mk_exp(1'b0, 1'b0, 32'h0000_005A, 2, 2, I2C_REG_TXR_RXR, 1'b0, 8'h00));
    step();
    // Next address is held on the bus through the stalled data phase
    drive_addr(8'h08, 1'b1, 3'd0);
    exp_q.push_back(mk_exp(1'b0, 1'b0, 32'h0000_005A, 2, 2, I2C_REG_CTR, 1'b1, 8'h80));
    HWDATA = 32'h0;
    collect(o1);
    step();
    drive_idle();
    HWDATA = 32'h0000_0080;
    collect(o2);
    rdata_model = 32'h0000_005A;
    e1 = exp_q.pop_front();
    e2 = exp_q.pop_front();
    n_vec++; if (o1.low !== e1.low) begin n_err++; $display("FAIL b2b_rd_low: got %0d want %0d", o1.low, e1.low); end
    n_vec++; if (o1.rdata !== e1.rdata) begin n_err++; $display("FAIL b2b_rd_data: got %h want %h", o1.rdata, e1.rdata); end
    n_vec++; if (o2.stb_first !== e2.stb_first) begin n_err++; $display("FAIL b2b_no_gap: got %b want %b", o2.stb_first, e2.stb_first); end
    n_vec++; if (o2.low !== e2.low) begin n_err++; $display("FAIL b2b_wr_low: got %0d want %0d", o2.low, e2.low); end
    n_vec++; if (o2.adr !== e2.adr) begin n_err++; $display("FAIL b2b_wr_adr: got %h want %h", o2.adr, e2.adr); end
    n_vec++; if (o2.we !== e2.we) begin n_err++; $display("FAIL b2b_wr_we: got %b want %b", o2.we, e2.we); end
    n_vec++; if (o2.dat !== e2.dat) begin n_err++; $display("FAIL b2b_wr_dat: got %h want %h", o2.dat, e2.dat); end
    n_vec++; if (o2.rdata !== e2.rdata) begin n_err++; $display("FAIL b2b_wr_hrdata: got %h want %h", o2.rdata, e2.rdata); end
    step();
  endtask

  task automatic test_stray_ack();
    rd_byte   = 8'hEE;
    ack_force = 1'b1;
    repeat (3) @(negedge HCLK);
    n_vec++; if (HRDATA !== rdata_model) begin n_err++; $display("FAIL stray_hrdata: got %h want %h", HRDATA, rdata_model); end
    n_vec++; if (HREADYOUT !== 1'b1) begin n_err++; $display("FAIL stray_ready: got %b want 1", HREADYOUT); end
    n_vec++; if (reg_stb_o !== 1'b0) begin n_err++; $display("FAIL stray_stb: got %b want 0", reg_stb_o); end
    ack_force = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_access();
    ack_mute = 1'b1;
    drive_addr(8'h04, 1'b0, 3'd0);
    step();
    drive_idle();
    @(negedge HCLK);
    n_vec++; if (reg_stb_o !== 1'b1) begin n_err++; $display("FAIL mid_stb_before: got %b want 1", reg_stb_o); end
    step();
    HRESET = 1'b1;
    step();
    HRESET = 1'b0;
    rdata_model = 32'h0;
    @(negedge HCLK);
    n_vec++; if (reg_stb_o !== 1'b0) begin n_err++; $display("FAIL mid_stb_after: got %b want 0", reg_stb_o); end
    n_vec++; if (HREADYOUT !== 1'b1) begin n_err++; $display("FAIL mid_ready: got %b want 1", HREADYOUT); end
    n_vec++; if (HRDATA !== rdata_model) begin n_err++; $display("FAIL mid_hrdata: got %h want %h", HRDATA, rdata_model); end
    ack_mute = 1'b0;
    step();
  endtask

`ifdef I2C_BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    obs_t o, e;
    ack_mute = 1'b1;
    drive_addr(8'h08, 1'b0, 3'd2);
    exp_q.push_back(mk_exp(1'b0, 1'b1, rdata_model, int'(TO) + 1, int'(TO), I2C_REG_CTR, 1'b0,
                           8'h00));
    step();
    drive_idle();
    collect(o);
    e = exp_q.pop_front();
    n_vec++; if (o.stb_cyc !== e.stb_cyc) begin n_err++; $display("FAIL to_stb: got %0d want %0d", o.stb_cyc, e.stb_cyc); end
    n_vec++; if (o.low !== e.low) begin n_err++; $display("FAIL to_low: got %0d want %0d", o.low, e.low); end
    n_vec++; if (o.resp_wait !== e.resp_wait) begin n_err++; $display("FAIL to_resp_wait: got %b want %b", o.resp_wait, e.resp_wait); end
    n_vec++; if (o.resp !== e.resp) begin n_err++; $display("FAIL to_resp: got %b want %b", o.resp, e.resp); end
    ack_mute = 1'b0;
    step();
  endtask
`endif

  initial begin
    HRESET = 1'b1;
    HSEL   = 1'b0;
    HADDR  = '0;
    HTRANS = HTRANS_IDLE;
    HWRITE = 1'b0;
    HSIZE  = 3'd0;
    HWDATA = 32'h0;
    test_reset();
    test_idle_bus();
    test_write_prerlo();
    test_read("rd_sr", 8'h10, 8'h41, 1);
    test_illegal();
    test_back_to_back();
    test_stray_ack();
    test_reset_mid_access();
    test_read("rd_prerhi", 8'h04, 8'h9C, 3);
`ifdef I2C_BRIDGE_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
